lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit between the CPU datapath and the byte-addressed, little-endian 32-bit data RAM (combinational read, write on the clock edge).
- Converts CPU requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned RAM accesses.
- Loads: extracts and sign/zero-extends the addressed byte or halfword.
- Sub-word stores: read-modify-write over two cycles, so the RAM only ever sees full-word writes.
- Misaligned or illegal requests: flagged with an error and perform no RAM write.

Parameters:
- WIDTH, 32, data/address width; only 32 is supported.
- MEM_ADDR_BITS, 10, byte-address bits decoded by the data RAM (1 KiB); used only by LSU_BOUNDS_CHECK_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 access size/sign
- req_addr  in  WIDTH  byte address
- req_wdata  in  WIDTH  store data; low byte/halfword used for SB/SH
- resp_valid  out  1  response valid
- resp_ready  in  1  CPU accepts response
- resp_rdata  out  WIDTH  load result, extended; 0 for stores and errors
- resp_err  out  1  request misaligned/illegal/out of range
- mem_we  out  1  RAM write enable
- mem_addr  out  WIDTH  RAM byte address, always word-aligned
- mem_wd  out  WIDTH  RAM write data
- mem_rd  in  WIDTH  RAM combinational read data

Behaviour:
- Reset (async, active-high):
  - state = IDLE; resp_valid = 0; resp_rdata = 0; resp_err = 0; all captured request registers = 0.
  - mem_we = 0 and mem_addr = 0 while reset is held.
  - Asserting rst in any state discards the in-flight request. No write occurs unless the WRITE-state clock edge has already passed.
- Request capture:
  - A request is accepted when req_valid && req_ready; req_ready = 1 only in IDLE.
  - Accepted fields are registered: we, funct3, addr, wdata.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is an error.
- Alignment: halfword requires addr[0] = 0; word requires addr[1:0] = 0. A violation is an error.
- States:
  - IDLE: on accept, go to ERR if error; else LOAD for loads; WRITE for SW; MERGE for SB/SH.
  - LOAD (1 cycle): register the extracted result.
    - Byte = mem_rd[8*a+7:8*a] with a = addr[1:0]; halfword = mem_rd[16*addr[1]+15:16*addr[1]].
    - Sign-extend for 000/001, zero-extend for 100/101; LW passes mem_rd through.
    - Next state RESP.
  - MERGE (1 cycle): register mem_rd with the addressed byte/halfword replaced by req_wdata[7:0]/[15:0]. Next state WRITE.
  - WRITE (1 cycle): mem_we = 1; mem_wd = merged word (SB/SH) or wdata (SW). Next state RESP.
  - ERR: transitions to RESP with resp_err = 1.
  - RESP: resp_valid = 1; hold resp_rdata/resp_err stable until resp_ready. On resp_valid && resp_ready go to IDLE.
- RAM-side outputs:
  - mem_addr = {addr_q[31:2], 2'b00} in LOAD/MERGE/WRITE; 0 otherwise.
  - mem_we is 1 only in WRITE, for exactly one cycle per store.
  - mem_wd = 0 outside WRITE.
- Latency from the accept edge (cycle 0): resp_valid rises in cycle 2 for loads and SW, cycle 3 for SB/SH, cycle 1 for errors.
- No overlap: a new request is accepted only after the previous response handshakes. resp_ready is ignored outside RESP.

Optional Feature:
- Macro LSU_BOUNDS_CHECK_EN.
- Defined: a request with any of req_addr[WIDTH-1:MEM_ADDR_BITS] nonzero is an error (resp_err = 1, no RAM access, ERR path).
- Undefined: upper address bits are passed through on mem_addr unchecked, and the RAM aliases them.

Test Plan:
- Preload bytes 0x10..0x13 = BB,AA,99,88; LB 0x13 -> resp_rdata 0xFFFFFF88 in cycle 2. LBU 0x13 -> 0x00000088. LW 0x10 -> 0x8899AABB.
- LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB; mem_we stays 0 throughout.
- SB 0x11, wdata 0x12345677:
  - mem_we high exactly in cycle 2, mem_addr 0x10, mem_wd 0x889977BB.
  - resp_valid in cycle 3; subsequent LW 0x10 -> 0x889977BB.
- SH 0x11 and LW 0x12 -> resp_err = 1, resp_rdata 0, resp_valid in cycle 1, mem_we never asserted, memory unchanged. SW with funct3 100 -> resp_err = 1.
- LW 0x10 with resp_ready held low 3 cycles -> resp_valid and resp_rdata held stable, req_ready = 0, new req_valid ignored. Accepted on the first resp_ready cycle; IDLE next cycle.
- SB 0x12 with rst pulsed during MERGE -> all outputs 0 immediately; no write, byte 0x12 still 0x99.
- With LSU_BOUNDS_CHECK_EN: LW 0x400 -> resp_err = 1. Without the macro: same request returns the word at 0x000.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// CPU-side request/response handshake bundle for lsu_ctrl.
// master = CPU datapath, slave = load/store unit.
interface lsu_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: turns LB/LH/LW/LBU/LHU/SB/SH/SW into word-aligned RAM accesses,
// sub-word stores as read-modify-write. Optional macro LSU_BOUNDS_CHECK_EN.
module lsu_ctrl #(
  parameter int WIDTH         = 32,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  lsu_ctrl_if.slave        cpu,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  if (WIDTH != 32 || MEM_ADDR_BITS < 2 || MEM_ADDR_BITS > WIDTH) begin : g_param_check
    $error("lsu_ctrl: WIDTH must be 32 and 2 <= MEM_ADDR_BITS <= WIDTH");
  end

  // ERR presents the error response directly so it is visible one cycle after accept.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MERGE, S_WRITE, S_ERR, S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             f3_legal;
  logic             misaligned;
  logic             out_of_range;
  logic             req_bad;
  logic [WIDTH-1:0] rd_byte_sh;
  logic [WIDTH-1:0] rd_half_sh;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] merge_mask;
  logic [WIDTH-1:0] merge_ins;
  logic [WIDTH-1:0] merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    if (cpu.req_we) f3_legal = (cpu.req_funct3 inside {3'b000, 3'b001, 3'b010});
    else            f3_legal = (cpu.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((cpu.req_funct3[1:0] == 2'b01) && cpu.req_addr[0]) ||
                 ((cpu.req_funct3[1:0] == 2'b10) && (cpu.req_addr[1:0] != 2'b00));
`ifdef LSU_BOUNDS_CHECK_EN
    out_of_range = |cpu.req_addr[WIDTH-1:MEM_ADDR_BITS];
`else
    out_of_range = 1'b0;
`endif
    req_bad = !f3_legal || misaligned || out_of_range;
  end

  always_comb begin
    rd_byte_sh = mem_rd >> {addr_q[1:0], 3'b000};
    rd_half_sh = mem_rd >> {addr_q[1], 4'b0000};
    case (funct3_q)
      3'b000:  load_val = {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
      3'b001:  load_val = {{16{rd_half_sh[15]}}, rd_half_sh[15:0]};
      3'b100:  load_val = {24'h000000, rd_byte_sh[7:0]};
      3'b101:  load_val = {16'h0000, rd_half_sh[15:0]};
      default: load_val = mem_rd;
    endcase
  end

  // Replicating the store data lets one mask select the target lane.
  always_comb begin
    if (funct3_q[1:0] == 2'b00) begin
      merge_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      merge_ins  = {4{wdata_q[7:0]}};
    end else begin
      merge_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
      merge_ins  = {2{wdata_q[15:0]}};
    end
    merged = (mem_rd & ~merge_mask) | (merge_ins & merge_mask);
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (cpu.req_valid) begin
          we_d     = cpu.req_we;
          funct3_d = cpu.req_funct3;
          addr_d   = cpu.req_addr;
          wdata_d  = cpu.req_wdata;
          rdata_d  = '0;
          err_d    = req_bad;
          if (req_bad)                          state_d = S_ERR;
          else if (!cpu.req_we)                 state_d = S_LOAD;
          else if (cpu.req_funct3[1:0] == 2'b10) state_d = S_WRITE;
          else                                  state_d = S_MERGE;
        end
      end
      S_LOAD: begin
        rdata_d = load_val;
        state_d = S_RESP;
      end
      S_MERGE: begin
        wdata_d = merged;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_ERR:   state_d = cpu.resp_ready ? S_IDLE : S_RESP;
      S_RESP:  if (cpu.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu.req_ready  = (state_q == S_IDLE);
    cpu.resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
    cpu.resp_rdata = rdata_q;
    cpu.resp_err   = err_q;
    mem_we         = (state_q == S_WRITE);
    mem_wd         = (state_q == S_WRITE) ? wdata_q : '0;
    if (state_q inside {S_LOAD, S_MERGE, S_WRITE}) mem_addr = {addr_q[WIDTH-1:2], 2'b00};
    else                                           mem_addr = '0;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: byte-array reference model predicts responses and RAM writes.
module tb_lsu_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.WIDTH(32)) cpu ();
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  lsu_ctrl #(.WIDTH(32), .MEM_ADDR_BITS(10)) dut (
    .clk(clk), .rst(rst), .cpu(cpu.slave),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  logic [7:0] ram     [0:1023];
  logic [7:0] ref_mem [0:1023];
  logic [9:0] ram_base;
  assign ram_base = {mem_addr[9:2], 2'b00};
  assign mem_rd = {ram[ram_base + 10'd3], ram[ram_base + 10'd2], ram[ram_base + 10'd1], ram[ram_base]};
  always @(posedge clk) begin
    if (mem_we) begin
      ram[ram_base]         <= mem_wd[7:0];
      ram[ram_base + 10'd1] <= mem_wd[15:8];
      ram[ram_base + 10'd2] <= mem_wd[23:16];
      ram[ram_base + 10'd3] <= mem_wd[31:24];
    end
  end

  typedef struct { logic [31:0] rdata; logic err; int lat; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] wd; int lat; } wr_t;
  resp_t exp_q[$];
  wr_t   wr_q[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte-granular memory, RAM aliases upper address bits.
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int size;
    logic bad;
    int ea;
    logic [31:0] val;
    int wb;
    size = 1 << f3[1:0];
    if (we) bad = (f3 > 3'd2);
    else    bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (f3[1:0] != 2'b11 && (addr % size) != 0) bad = 1'b1;
`ifdef LSU_BOUNDS_CHECK_EN
    if (addr >= 32'd1024) bad = 1'b1;
`endif
    ea = int'(addr % 32'd1024);
    if (bad) begin
      exp_q.push_back('{32'h0, 1'b1, 1});
    end else if (!we) begin
      val = 32'h0;
      for (int i = 0; i < size; i++) val = val | (32'(ref_mem[ea + i]) << (8 * i));
      if (!f3[2] && size < 4 && val[8 * size - 1]) val = val - (32'd1 << (8 * size));
      exp_q.push_back('{val, 1'b0, 2});
    end else begin
      for (int i = 0; i < size; i++) ref_mem[ea + i] = wdata[8 * i +: 8];
      wb = ea - (ea % 4);
      val = {ref_mem[wb + 3], ref_mem[wb + 2], ref_mem[wb + 1], ref_mem[wb]};
      wr_q.push_back('{addr & 32'hFFFF_FFFC, val, (size == 4) ? 1 : 2});
      exp_q.push_back('{32'h0, 1'b0, (size == 4) ? 2 : 3});
    end
  endtask

  // Monitor: compares every presented response and every RAM write to the queues.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (cpu.req_valid && cpu.req_ready) acc_cyc = cyc;
      if (cpu.resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL resp_unexpected actual=valid required=none (cycle %0d)", cyc);
        end else begin
          check("resp_rdata", cpu.resp_rdata, exp_q[0].rdata);
          check("resp_err", {31'b0, cpu.resp_err}, {31'b0, exp_q[0].err});
          check("req_ready_busy", {31'b0, cpu.req_ready}, 32'h0);
          if (!prev_valid) check("resp_latency", 32'(cyc - acc_cyc), 32'(exp_q[0].lat));
          if (cpu.resp_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = cpu.resp_valid;
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL write_unexpected actual addr=0x%08h wd=0x%08h required=no write", mem_addr, mem_wd);
        end else begin
          check("mem_addr", mem_addr, wr_q[0].addr);
          check("mem_wd", mem_wd, wr_q[0].wd);
          check("write_cycle", 32'(cyc - acc_cyc), 32'(wr_q[0].lat));
          void'(wr_q.pop_front());
        end
      end
      if (cpu.req_ready) begin
        check("idle_mem_addr", mem_addr, 32'h0);
        check("idle_mem_wd", mem_wd, 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!cpu.resp_valid && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (!cpu.resp_valid) begin
      failures++;
      $display("FAIL resp_timeout actual=no resp_valid required=resp_valid within 10 cycles");
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    cpu.req_we     = we;
    cpu.req_funct3 = f3;
    cpu.req_addr   = addr;
    cpu.req_wdata  = wdata;
    cpu.req_valid  = 1'b1;
    step();
    cpu.req_valid  = 1'b0;
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall);
    model_req(we, f3, addr, wdata);
    issue(we, f3, addr, wdata);
    wait_resp();
    repeat (stall) step();
    cpu.resp_ready = 1'b1;
    step();
    cpu.resp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;
    logic [31:0] a;
    logic [7:0] b;
    cpu.req_valid = 1'b0; cpu.req_we = 1'b0; cpu.req_funct3 = 3'b0;
    cpu.req_addr = 32'h0; cpu.req_wdata = 32'h0; cpu.resp_ready = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom);
      ram[i] = b;
      ref_mem[i] = b;
    end
    ram[16] = 8'hBB; ram[17] = 8'hAA; ram[18] = 8'h99; ram[19] = 8'h88;
    ref_mem[16] = 8'hBB; ref_mem[17] = 8'hAA; ref_mem[18] = 8'h99; ref_mem[19] = 8'h88;

    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", {31'b0, cpu.resp_valid}, 32'h0);
    check("rst_resp_rdata", cpu.resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, cpu.resp_err}, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    step();

    run_req(1'b0, 3'b000, 32'h13, 32'h0, 0);          // LB
    run_req(1'b0, 3'b100, 32'h13, 32'h0, 0);          // LBU
    run_req(1'b0, 3'b010, 32'h10, 32'h0, 0);          // LW
    run_req(1'b0, 3'b001, 32'h12, 32'h0, 1);          // LH
    run_req(1'b0, 3'b101, 32'h10, 32'h0, 0);          // LHU
    run_req(1'b1, 3'b000, 32'h11, 32'h1234_5677, 0);  // SB
    run_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
    run_req(1'b1, 3'b001, 32'h11, 32'hDEAD_BEEF, 0);  // SH misaligned
    run_req(1'b0, 3'b010, 32'h12, 32'h0, 2);          // LW misaligned
    run_req(1'b1, 3'b100, 32'h10, 32'h0, 0);          // SW with illegal funct3
    run_req(1'b0, 3'b010, 32'h10, 32'h0, 0);

    // Response back-pressure with a competing request that must be ignored.
    model_req(1'b0, 3'b010, 32'h10, 32'h0);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    wait_resp();
    cpu.req_we = 1'b1; cpu.req_funct3 = 3'b010; cpu.req_addr = 32'h20;
    cpu.req_wdata = $urandom; cpu.req_valid = 1'b1;
    repeat (3) step();
    cpu.req_valid = 1'b0;
    cpu.resp_ready = 1'b1;
    step();
    cpu.resp_ready = 1'b0;
    check("idle_after_resp", {31'b0, cpu.req_ready}, 32'h1);

    // Reset during MERGE of SB 0x12: no write, byte keeps its old value.
    issue(1'b1, 3'b000, 32'h12, 32'h0000_0055);
    #1 rst = 1'b1;
    #1;
    check("arst_resp_valid", {31'b0, cpu.resp_valid}, 32'h0);
    check("arst_resp_rdata", cpu.resp_rdata, 32'h0);
    check("arst_resp_err", {31'b0, cpu.resp_err}, 32'h0);
    check("arst_mem_we", {31'b0, mem_we}, 32'h0);
    check("arst_mem_addr", mem_addr, 32'h0);
    check("arst_mem_wd", mem_wd, 32'h0);
    #1 rst = 1'b0;
    step();
    step();
    check("arst_byte12", {24'h0, ram[18]}, 32'h99);
    check("arst_req_ready", {31'b0, cpu.req_ready}, 32'h1);

    run_req(1'b0, 3'b010, 32'h400, 32'h0, 0);         // bounds / aliasing

    for (int n = 0; n < 200; n++) begin
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_FC00);
      run_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 2));
    end

    step();
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    check("wr_q_empty", 32'(wr_q.size()), 32'h0);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) mism++;
    check("ram_image", 32'(mism), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
